// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with a built-in channel scanner.
//
// Direct mode decodes a handshaked index onto a registered one-hot select.
// Scan mode walks the channels itself. Each channel is held for dwell+1
// cycles, and wrap pulses when the scan returns to the lowest channel.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en, mode          block enable; 0 = direct decode, 1 = scan
//   sel_valid/sel     index handshake (direct mode); sel_ready is the accept
//   dwell             per-channel hold, sampled at each channel start
//   mask              scan channel enable (only with DECSCAN_MASK_EN)
//   out, cur          registered one-hot select and its index
//   wrap, busy        wrap-around pulse; high while scanning
//
// Optional feature macro: DECSCAN_MASK_EN adds the mask port and lets the
// scan skip disabled channels.
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef DECSCAN_MASK_EN
    input  logic [2**SEL_W-1:0]   mask,
`endif
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      cur,
    output logic                  wrap,
    output logic                  busy
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [OUT_W-1:0]   scan_mask;
    logic [SEL_W:0]     first_ch;   // {found, index}
    logic [SEL_W:0]     next_ch;    // {found, index}

`ifdef DECSCAN_MASK_EN
    assign scan_mask = mask;
`else
    assign scan_mask = '1;
`endif

    // First enabled channel at or above start, searching upward with
    // wrap-around. Returns {found, index}. The loop runs downward so that
    // the smallest offset is the last write and therefore wins.
    function automatic logic [SEL_W:0] find_from(input logic [SEL_W-1:0] start,
                                                 input logic [OUT_W-1:0] m);
        logic [SEL_W:0]   r;
        logic [SEL_W-1:0] idx;
        r = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (m[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

    assign first_ch  = find_from('0, scan_mask);
    assign next_ch   = find_from(cur + SEL_ONE, scan_mask);
    assign sel_ready = (state == DIRECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            cur   <= '0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (!en) begin
            // cur holds on purpose, so software can see where the block stopped.
            state <= IDLE;
            out   <= '0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (state != SCAN && mode) begin
            // Scan (re)start from IDLE or DIRECT always begins at the lowest channel.
            state <= SCAN;
            busy  <= 1'b1;
            wrap  <= 1'b0;
            if (first_ch[SEL_W]) begin
                out <= onehot(first_ch[SEL_W-1:0]);
                cur <= first_ch[SEL_W-1:0];
                cnt <= dwell;
            end else begin
                out <= '0;
                cnt <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= DIRECT;
                end
                DIRECT: begin
                    if (sel_valid) begin
                        out <= onehot(sel);
                        cur <= sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state <= DIRECT;
                        busy  <= 1'b0;
                        wrap  <= 1'b0;
                        cnt   <= '0;
                    end else if (out == '0) begin
                        // Parked on an empty mask. Resume above cur without a wrap pulse.
                        wrap <= 1'b0;
                        if (next_ch[SEL_W]) begin
                            out <= onehot(next_ch[SEL_W-1:0]);
                            cur <= next_ch[SEL_W-1:0];
                            cnt <= dwell;
                        end
                    end else if (cnt != '0) begin
                        cnt  <= cnt - DWELL_ONE;
                        wrap <= 1'b0;
                    end else if (next_ch[SEL_W]) begin
                        out  <= onehot(next_ch[SEL_W-1:0]);
                        cur  <= next_ch[SEL_W-1:0];
                        cnt  <= dwell;
                        // A step to a lower index means the scan wrapped around.
                        wrap <= (next_ch[SEL_W-1:0] < cur);
                    end else begin
                        out  <= '0;
                        cnt  <= '0;
                        wrap <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL_W=8).
// Inputs change 1 time unit after a rising edge. Outputs are read at the
// same point, so each check shows the effect of the edge just taken.
module tb_decoder_scan;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 2**SEL_W;

    logic               clk = 1'b0;
    logic               rst, en, mode, sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
`ifdef DECSCAN_MASK_EN
    logic [OUT_W-1:0]   mask;
`endif
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   cur;
    logic               wrap, busy;

    int n_cmp = 0;
    int n_err = 0;

    decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
        .dwell(dwell),
`ifdef DECSCAN_MASK_EN
        .mask(mask),
`endif
        .out(out), .cur(cur), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
`ifdef DECSCAN_MASK_EN
        mask = '1;
`endif
        step(); step();
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Direct decode.
        en = 1'b1; mode = 1'b0;
        step();
        chk("dir_ready", sel_ready, 1);
        chk("dir_entry_out", out, 0);
        sel = 3'd5; sel_valid = 1'b1;
        step();
        chk("dir5_out", out, 32'h20);
        chk("dir5_cur", cur, 5);
        sel = 3'd0;
        step();
        chk("dir0_out", out, 32'h01);
        chk("dir0_cur", cur, 0);
        sel_valid = 1'b0; sel = 3'd6;
        step();
        chk("dir_hold", out, 32'h01);

        // Scan, dwell=2: three cycles per channel, wrap at 24 cycles.
        // sel_valid is held high to show it is ignored while scanning.
        dwell = 8'd2; mode = 1'b1; sel_valid = 1'b1; sel = 3'd3;
        step();
        chk("scan_t0_out", out, 32'h01);
        chk("scan_t0_busy", busy, 1);
        chk("scan_t0_wrap", wrap, 0);
        chk("scan_ready", sel_ready, 0);
        for (int k = 1; k <= 37; k++) begin
            step();
            chk($sformatf("scan_cur_k%0d", k), cur, (k / 3) % 8);
            chk($sformatf("scan_out_k%0d", k), out, 32'h1 << ((k / 3) % 8));
            chk($sformatf("scan_wrap_k%0d", k), wrap, (k == 24) ? 1 : 0);
        end

        // Mode switch mid-dwell on channel 4.
        mode = 1'b0; sel_valid = 1'b0;
        step();
        chk("msw_out", out, 32'h10);
        chk("msw_cur", cur, 4);
        chk("msw_ready", sel_ready, 1);
        chk("msw_busy", busy, 0);
        step();
        chk("msw_hold", out, 32'h10);
        sel = 3'd1; sel_valid = 1'b1;
        step();
        chk("msw_acc_out", out, 32'h02);

        // en falls on the same edge as an accept: en wins.
        en = 1'b0; sel = 3'd6;
        step();
        chk("enacc_out", out, 0);
        chk("enacc_cur", cur, 1);
        chk("enacc_ready", sel_ready, 0);

        // Enable drop mid-dwell, then restart at channel 0.
        en = 1'b1; mode = 1'b1; sel_valid = 1'b0;
        step();
        chk("en_scan0", out, 32'h01);
        step(); step(); step(); step();
        chk("en_mid_cur", cur, 1);
        en = 1'b0;
        step();
        chk("endrop_out", out, 0);
        chk("endrop_cur", cur, 1);
        chk("endrop_busy", busy, 0);
        chk("endrop_wrap", wrap, 0);
        en = 1'b1;
        step();
        chk("enre_out", out, 32'h01);
        chk("enre_cur", cur, 0);

        // Dwell changed mid-dwell takes effect from the next channel.
        dwell = 8'd0;
        step(); step();
        chk("dwchg_k2", cur, 0);
        step();
        chk("dwchg_k3", cur, 1);
        step();
        chk("dwchg_k4", cur, 2);
        step();
        chk("dwchg_k5", out, 32'h08);

        // Maximum dwell: 256 cycles per channel.
        dwell = 8'hFF; mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        chk("dmax_start", cur, 0);
        for (int k = 1; k <= 255; k++) step();
        chk("dmax_k255", cur, 0);
        step();
        chk("dmax_k256", cur, 1);
        chk("dmax_k256_out", out, 32'h02);

        // Reset held two cycles mid-scan.
        rst = 1'b1;
        step(); step();
        chk("rst2_out", out, 0);
        chk("rst2_cur", cur, 0);
        chk("rst2_wrap", wrap, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_ready", sel_ready, 0);

`ifdef DECSCAN_MASK_EN
        // Masked scan over channels 1, 4 and 7.
        mask = 8'b10010010; dwell = 8'd0; en = 1'b1; mode = 1'b1;
        rst = 1'b0;
        step();
        chk("msk_c1", out, 32'h02);
        chk("msk_c1_wrap", wrap, 0);
        step();
        chk("msk_c4", out, 32'h10);
        step();
        chk("msk_c7", out, 32'h80);
        step();
        chk("msk_c1b", out, 32'h02);
        chk("msk_c1b_wrap", wrap, 1);
        step();
        chk("msk_c4b", out, 32'h10);
        chk("msk_c4b_wrap", wrap, 0);
        mask = 8'h00;
        step();
        chk("msk_zero_out", out, 0);
        chk("msk_zero_cur", cur, 4);
        chk("msk_zero_busy", busy, 1);
        mask = 8'h01;
        step();
        chk("msk_res_out", out, 32'h01);
        chk("msk_res_wrap", wrap, 0);
`else
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
